ui_mmio_master: RTL and testbench
=================================

Name: ui_mmio_master

Overview:
- Bus-side initiator for the UI peripheral controller.
- Converts CPU load/store requests (req/ack handshake, full byte address) into the controller's device-select / write-enable / data interface, and returns read data.
- Also polls the KEY device in the background and latches key-press events into a sticky, CPU-readable event register that drives an interrupt line.
- Sits between the CPU data-memory port decode and the UI controller.

Parameters:
- DBITS, 32, data and address width.
- BASE_ADDR, 32'hF000_0000, base of the UI MMIO window.
- POLL_PERIOD, 1024, clk cycles between background KEY polls; minimum 4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- cpu_req  in  1  access request, level; held until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load; valid with cpu_req.
- cpu_addr  in  DBITS  byte address; valid with cpu_req.
- cpu_wdata  in  DBITS  store data.
- cpu_rdata  out  DBITS  load data; valid while cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ack; 1 = unmapped or illegal access.
- ui_dev  out  2  device select to the UI controller.
- ui_wrt_en  out  1  write enable to the UI controller.
- ui_wdata  out  DBITS  write data to the UI controller.
- ui_rdata  in  DBITS  read data from the UI controller; combinational on ui_dev.
- key_irq  out  1  high while any key event bit is set.

Behaviour:
- Address map (offset from BASE_ADDR):
  - 0x00 HEX (R/W)
  - 0x04 LEDR (R/W)
  - 0x10 KEY (RO)
  - 0x14 SW (RO)
  - 0x18 KEYEVT (R, W1C)
  - Any other address is unmapped, including unaligned addresses (addr[1:0] != 0) and addresses outside the window.
- Reset values: state IDLE, cpu_ack 0, cpu_err 0, cpu_rdata 0, ui_wrt_en 0, ui_dev KEY, ui_wdata 0, key events 0, previous-key snapshot 0, poll counter 0, poll_pending 0.
- FSM states: IDLE, ACCESS, POLL, RESP.
- IDLE:
  - cpu_req=1 goes to ACCESS and registers we/addr/wdata.
  - Otherwise, poll_pending=1 goes to POLL.
  - CPU requests have priority over polling.
- ACCESS (exactly 1 cycle):
  - Drives ui_dev from the decoded address.
  - ui_wrt_en=1 only for a store to HEX or LEDR; ui_wdata = registered wdata.
  - On a load, cpu_rdata captures ui_rdata at the end of the cycle.
  - KEYEVT load: cpu_rdata = {0, events[3:0]}, no device access; events are then cleared, except bits newly set in the same cycle, which stay set.
  - KEYEVT store: events &= ~wdata[3:0].
  - Unmapped access, or store to KEY/SW: no device access, ui_wrt_en=0, cpu_rdata=0, cpu_err=1.
  - Next state RESP.
- RESP (1 cycle): cpu_ack=1, cpu_rdata/cpu_err held. Next state IDLE. ui_wrt_en=0.
- Handshake and latency:
  - Request sampled in IDLE at cycle t; ack at t+2.
  - A req still high in the cycle after ack is a new transaction.
  - Maximum throughput: 1 access per 3 cycles.
- Poll counter:
  - Increments every cycle.
  - At POLL_PERIOD-1, sets poll_pending and wraps to 0.
  - poll_pending stays set until POLL is entered; there is no double-queue.
- POLL (1 cycle):
  - ui_dev=KEY, ui_wrt_en=0.
  - pressed = ui_rdata[3:0]; events |= pressed & ~prev; prev <= pressed.
  - Clears poll_pending. Next state IDLE.
  - cpu_req arriving during POLL waits one extra cycle.
- key_irq = |events, registered with the event bits.
- Simultaneous event set and W1C clear on the same bit: set wins.
- Reset mid-transaction: abort immediately, no ack issued, all values return to reset values.
- Upper ui_rdata bits are passed through unmodified.

Decomposition:
- Shared package ui_pkg:
  - UI_KEY=2'd0, UI_SW=2'd1, UI_LEDR=2'd2, UI_HEX=2'd3
  - Offset constants: OFF_HEX, OFF_LEDR, OFF_KEY, OFF_SW, OFF_KEYEVT
  - FSM state encoding
- Sub-module ui_key_event_latch: edge detector, sticky event bits, clear-on-read / W1C, set priority, irq output.

Test Plan:
- Store 0x0000_1234 to BASE+0x00 → one cycle with ui_dev=HEX, ui_wrt_en=1, ui_wdata=0x1234; cpu_ack 2 cycles after req, cpu_err=0.
- Load BASE+0x14 with ui_rdata=0x2A5 → cpu_rdata=0x0000_02A5 with ack, ui_wrt_en never asserted.
- Store to BASE+0x10, load from BASE+0x20, load from BASE+0x02 → each acks with cpu_err=1, cpu_rdata=0, ui_wrt_en=0.
- Background poll with POLL_PERIOD=4:
  - KEY reads 0x0 then 0x5 → events=0x5, key_irq=1.
  - Load BASE+0x18 → rdata=0x5, then events=0, key_irq=0.
  - Holding 0x5 on later polls sets nothing.
- Poll coincides with cpu_req → CPU access serviced first; poll occurs next idle cycle; events updated correctly.
- Reset asserted during ACCESS of a LEDR store → no ack; all outputs at reset values; next request completes normally.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared UI MMIO definitions: device selects, window offsets, FSM and decode encodings.
// No logic of its own.
// Nothing here carries state or backpressure.
package ui_pkg;

  localparam logic [1:0] UI_KEY  = 2'd0;
  localparam logic [1:0] UI_SW   = 2'd1;
  localparam logic [1:0] UI_LEDR = 2'd2;
  localparam logic [1:0] UI_HEX  = 2'd3;

  localparam logic [7:0] OFF_HEX    = 8'h00;
  localparam logic [7:0] OFF_LEDR   = 8'h04;
  localparam logic [7:0] OFF_KEY    = 8'h10;
  localparam logic [7:0] OFF_SW     = 8'h14;
  localparam logic [7:0] OFF_KEYEVT = 8'h18;

  typedef enum logic [1:0] {IDLE, ACCESS, POLL, RESP} ui_state_t;

  // Decoded register region of a CPU access.
  typedef enum logic [2:0] {
    RGN_HEX, RGN_LEDR, RGN_KEY, RGN_SW, RGN_KEYEVT, RGN_NONE
  } ui_rgn_t;

  // Device select for a region; regions without a device park on KEY (read-only, harmless).
  function automatic logic [1:0] rgn_dev(input ui_rgn_t rgn);
    case (rgn)
      RGN_HEX:  return UI_HEX;
      RGN_LEDR: return UI_LEDR;
      RGN_SW:   return UI_SW;
      default:  return UI_KEY;
    endcase
  endfunction

  // Only the output devices accept stores.
  function automatic logic rgn_writable(input ui_rgn_t rgn);
    return (rgn == RGN_HEX) || (rgn == RGN_LEDR);
  endfunction

endpackage

// File: rtl/ui_mmio_master_if.sv
// CPU-side req/ack bus plus UI-controller device bus of the MMIO master.
// Signal bundle only, no latency.
// cpu_req is held until cpu_ack; the UI side has no backpressure.
interface ui_mmio_master_if #(
  parameter int DBITS = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [DBITS-1:0] cpu_addr;
  logic [DBITS-1:0] cpu_wdata;
  logic [DBITS-1:0] cpu_rdata;
  logic             cpu_ack;
  logic             cpu_err;
  logic [1:0]       ui_dev;
  logic             ui_wrt_en;
  logic [DBITS-1:0] ui_wdata;
  logic [DBITS-1:0] ui_rdata;
  logic             key_irq;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ui_rdata,
    output cpu_rdata, cpu_ack, cpu_err, ui_dev, ui_wrt_en, ui_wdata, key_irq
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ui_rdata,
    input  cpu_rdata, cpu_ack, cpu_err, ui_dev, ui_wrt_en, ui_wdata, key_irq
  );
endinterface

// File: rtl/ui_key_event_latch.sv
// Rising-edge detector on the 4 KEY lines with sticky event bits and an irq.
// Events and irq update one cycle after a sample / clear strobe.
// No backpressure; a set in the same cycle as a clear wins.
module ui_key_event_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_sample,
  input  logic [3:0] i_pressed,
  input  logic       i_rd_clr,
  input  logic       i_w1c_vld,
  input  logic [3:0] i_w1c_mask,
  output logic [3:0] o_events,
  output logic       o_irq
);
  logic [3:0] r_events;
  logic [3:0] r_prev;
  logic       r_irq;
  logic [3:0] w_set;
  logic [3:0] w_clr;
  logic [3:0] w_next;

  // New presses since the last sample set bits; read clears all, W1C clears the mask.
  always_comb begin
    w_set  = i_sample ? (i_pressed & ~r_prev) : 4'h0;
    w_clr  = i_rd_clr ? 4'hF : (i_w1c_vld ? i_w1c_mask : 4'h0);
    w_next = (r_events & ~w_clr) | w_set;
  end

  // Event bits, irq and the previous-key snapshot are all registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_events <= 4'h0;
      r_prev   <= 4'h0;
      r_irq    <= 1'b0;
    end else begin
      r_events <= w_next;
      r_irq    <= |w_next;
      if (i_sample) r_prev <= i_pressed;
    end
  end

  assign o_events = r_events;
  assign o_irq    = r_irq;
endmodule

// File: rtl/ui_mmio_master.sv
// CPU load/store to UI-controller bridge with background KEY polling and key events.
// Request sampled in IDLE is acked two cycles later; a pending poll can add one cycle.
// cpu_req is held by the CPU until cpu_ack; CPU requests take priority over polls.
module ui_mmio_master
  import ui_pkg::*;
#(
  parameter int               DBITS       = 32,
  parameter logic [DBITS-1:0] BASE_ADDR   = 32'hF000_0000,
  parameter int               POLL_PERIOD = 1024
) (
  input logic              clk,
  input logic              reset,
  ui_mmio_master_if.master bus
);
  localparam int               CNT_W    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);

  ui_state_t        r_state;
  logic             r_we;
  ui_rgn_t          r_rgn;
  logic             r_cpu_ack;
  logic             r_cpu_err;
  logic [DBITS-1:0] r_cpu_rdata;
  logic [1:0]       r_ui_dev;
  logic             r_ui_wrt_en;
  logic [DBITS-1:0] r_ui_wdata;
  logic [CNT_W-1:0] r_poll_cnt;
  logic             r_poll_pending;

  logic [DBITS-1:0] w_off;
  ui_rgn_t          w_rgn;
  logic             w_illegal;
  logic [DBITS-1:0] w_acc_rdata;
  logic             w_poll_wrap;
  logic             w_poll_sample;
  logic             w_evt_rd_clr;
  logic             w_evt_w1c;
  logic [3:0]       w_events;
  logic             w_key_irq;

  assign w_off = bus.cpu_addr - BASE_ADDR;

  // Exact offset match; unaligned or out-of-window addresses fall through to RGN_NONE.
  always_comb begin
    w_rgn = RGN_NONE;
    if      (w_off == DBITS'(OFF_HEX))    w_rgn = RGN_HEX;
    else if (w_off == DBITS'(OFF_LEDR))   w_rgn = RGN_LEDR;
    else if (w_off == DBITS'(OFF_KEY))    w_rgn = RGN_KEY;
    else if (w_off == DBITS'(OFF_SW))     w_rgn = RGN_SW;
    else if (w_off == DBITS'(OFF_KEYEVT)) w_rgn = RGN_KEYEVT;
  end

  assign w_illegal = (r_rgn == RGN_NONE) ||
                     (r_we && ((r_rgn == RGN_KEY) || (r_rgn == RGN_SW)));

  // Load data seen at the end of ACCESS; errors and stores return zero.
  always_comb begin
    w_acc_rdata = '0;
    if (!r_we && !w_illegal) begin
      if (r_rgn == RGN_KEYEVT) w_acc_rdata = {{(DBITS-4){1'b0}}, w_events};
      else                     w_acc_rdata = bus.ui_rdata;
    end
  end

  // Access sequencer; device select and write enable are set up on entry to ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_rgn       <= RGN_NONE;
      r_cpu_ack   <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_cpu_rdata <= '0;
      r_ui_dev    <= UI_KEY;
      r_ui_wrt_en <= 1'b0;
      r_ui_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_req) begin
            r_state     <= ACCESS;
            r_we        <= bus.cpu_we;
            r_rgn       <= w_rgn;
            r_ui_wdata  <= bus.cpu_wdata;
            r_ui_dev    <= rgn_dev(w_rgn);
            r_ui_wrt_en <= bus.cpu_we && rgn_writable(w_rgn);
          end else if (r_poll_pending) begin
            r_state     <= POLL;
            r_ui_dev    <= UI_KEY;
            r_ui_wrt_en <= 1'b0;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_cpu_ack   <= 1'b1;
          r_cpu_err   <= w_illegal;
          r_cpu_rdata <= w_acc_rdata;
          r_ui_wrt_en <= 1'b0;
          r_ui_dev    <= UI_KEY;
        end
        POLL: begin
          r_state <= IDLE;
        end
        RESP: begin
          r_state   <= IDLE;
          r_cpu_ack <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_poll_wrap = (r_poll_cnt == CNT_LAST);

  // Free-running poll timer; a wrap re-arms the pending flag even as POLL retires it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_poll_cnt     <= '0;
      r_poll_pending <= 1'b0;
    end else begin
      r_poll_cnt     <= w_poll_wrap ? '0 : r_poll_cnt + 1'b1;
      r_poll_pending <= w_poll_wrap || (r_poll_pending && (r_state != POLL));
    end
  end

  assign w_poll_sample = (r_state == POLL);
  assign w_evt_rd_clr  = (r_state == ACCESS) && !r_we && (r_rgn == RGN_KEYEVT);
  assign w_evt_w1c     = (r_state == ACCESS) &&  r_we && (r_rgn == RGN_KEYEVT);

  ui_key_event_latch u_key_evt (
    .clk        (clk),
    .reset      (reset),
    .i_sample   (w_poll_sample),
    .i_pressed  (bus.ui_rdata[3:0]),
    .i_rd_clr   (w_evt_rd_clr),
    .i_w1c_vld  (w_evt_w1c),
    .i_w1c_mask (r_ui_wdata[3:0]),
    .o_events   (w_events),
    .o_irq      (w_key_irq)
  );

  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_err   = r_cpu_err;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.ui_dev    = r_ui_dev;
  assign bus.ui_wrt_en = r_ui_wrt_en;
  assign bus.ui_wdata  = r_ui_wdata;
  assign bus.key_irq   = w_key_irq;
endmodule

// File: tb/tb_ui_mmio_master.sv
// Directed bench for ui_mmio_master with a cycle-level reference of the access/poll rules.
// Outputs are compared on every falling edge against the reference.
// CPU side follows req/ack; the UI controller is a four-register array read by ui_dev.
module tb_ui_mmio_master;
  localparam logic [31:0] BASE   = 32'hF000_0000;
  localparam int          PERIOD = 4;

  logic        clk;
  logic        reset;
  logic [31:0] dev_val [4];

  int n_vec  = 0;
  int n_miss = 0;
  int n_wr   = 0;
  logic [1:0]  last_wr_dev;
  logic [31:0] last_wr_dat;

  ui_mmio_master_if #(.DBITS(32)) bus ();

  ui_mmio_master #(.DBITS(32), .BASE_ADDR(BASE), .POLL_PERIOD(PERIOD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.ui_rdata = dev_val[bus.ui_dev];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register map as the CPU sees it: device number, 4 for KEYEVT, -1 unmapped.
  function automatic int classify(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    case (off)
      32'h00:  return 3;
      32'h04:  return 2;
      32'h10:  return 0;
      32'h14:  return 1;
      32'h18:  return 4;
      default: return -1;
    endcase
  endfunction

  // Reference: a transaction occupies two cycles after acceptance (access, then ack);
  // a poll occupies one. Expectations describe the cycle that begins at this edge.
  int          m_cnt, m_busy, m_kind;
  bit          m_pend, m_poll, m_we, m_live;
  logic [31:0] m_wd;
  logic [3:0]  m_ev, m_prev;
  bit          e_ack, e_err, e_wr, e_chk_rd, e_rst;
  logic [31:0] e_rdata, e_wdata;
  int          e_dev;

  initial m_live = 1'b0;

  always @(posedge clk) begin : model
    bit         free, term, was_poll, bad;
    logic [3:0] pressed;
    m_live = 1'b1;
    if (reset) begin
      m_cnt = 0; m_busy = 0; m_pend = 0; m_poll = 0; m_ev = 4'h0; m_prev = 4'h0;
      m_kind = -1; m_we = 0; m_wd = 32'h0;
      e_ack = 0; e_err = 0; e_rdata = 32'h0; e_chk_rd = 1; e_wr = 0; e_wdata = 32'h0;
      e_dev = 0; e_rst = 1;
    end else begin
      e_rst = 0;
      if (m_busy == 2) begin
        bad      = (m_kind < 0) || (m_we && (m_kind == 0 || m_kind == 1));
        e_err    = bad;
        e_chk_rd = bad || !m_we;
        if (bad) e_rdata = 32'h0;
        else if (m_kind == 4) begin
          if (m_we) m_ev = m_ev & ~m_wd[3:0];
          else begin
            e_rdata = {28'h0, m_ev};
            m_ev    = 4'h0;
          end
        end else if (!m_we) e_rdata = dev_val[m_kind];
      end
      if (m_poll) begin
        pressed = dev_val[0][3:0];
        m_ev    = m_ev | (pressed & ~m_prev);
        m_prev  = pressed;
      end
      free     = (m_busy == 0) && !m_poll;
      was_poll = m_poll;
      term     = (m_cnt == PERIOD - 1);
      m_poll   = 0;
      if (m_busy > 0) m_busy--;
      else if (free && bus.cpu_req) begin
        m_busy = 2;
        m_we   = bus.cpu_we;
        m_kind = classify(bus.cpu_addr);
        m_wd   = bus.cpu_wdata;
      end else if (free && m_pend) m_poll = 1;
      m_pend  = (m_pend && !was_poll) || term;
      m_cnt   = term ? 0 : m_cnt + 1;
      e_ack   = (m_busy == 1);
      e_wr    = (m_busy == 2) && m_we && (m_kind == 2 || m_kind == 3);
      e_wdata = m_wd;
      if ((m_busy == 2) && (m_kind >= 0) && (m_kind <= 3) && !(m_we && m_kind < 2))
        e_dev = m_kind;
      else
        e_dev = m_poll ? 0 : -1;
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    if (bus.ui_wrt_en === 1'b1) begin
      n_wr++;
      last_wr_dev = bus.ui_dev;
      last_wr_dat = bus.ui_wdata;
    end
    if (m_live) begin
      chk("cpu_ack", bus.cpu_ack, e_ack);
      chk("ui_wrt_en", bus.ui_wrt_en, e_wr);
      chk("key_irq", bus.key_irq, |m_ev);
      if (e_ack || e_rst) begin
        chk("cpu_err", bus.cpu_err, e_err);
        if (e_chk_rd) chk("cpu_rdata", bus.cpu_rdata, e_rdata);
      end
      if (e_wr || e_rst) chk("ui_wdata", bus.ui_wdata, e_wdata);
      if (e_dev >= 0) chk("ui_dev", bus.ui_dev, 32'(e_dev));
    end
  end

  task automatic do_acc(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    bit got;
    got = 0;
    rd  = 32'h0;
    er  = 1'b0;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) begin
        got = 1;
        rd  = bus.cpu_rdata;
        er  = bus.cpu_err;
      end
    end
    bus.cpu_req = 1'b0;
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL ack_timeout: no cpu_ack for addr %0h within 20 cycles", addr);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "time limit");
  end

  logic [31:0] rd;
  logic        er;
  int          wr0;
  bit          seen;

  initial begin : stim
    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    dev_val[0] = 32'h0;
    dev_val[1] = 32'h0;
    dev_val[2] = 32'h0;
    dev_val[3] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.cpu_ack, 0);
    chk("rst_dev_key", bus.ui_dev, 0);
    chk("rst_irq", bus.key_irq, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Store to HEX: single write pulse with the store data.
    wr0 = n_wr;
    do_acc(1, BASE + 32'h00, 32'h0000_1234, rd, er);
    chk("hex_st_err", er, 0);
    chk("hex_st_pulses", n_wr - wr0, 1);
    chk("hex_st_dev", last_wr_dev, 3);
    chk("hex_st_data", last_wr_dat, 32'h0000_1234);

    // Loads: SW value, HEX with upper bits passed through.
    dev_val[1] = 32'h0000_02A5;
    dev_val[3] = 32'hDEAD_BEEF;
    wr0 = n_wr;
    do_acc(0, BASE + 32'h14, 32'h0, rd, er);
    chk("sw_ld_data", rd, 32'h0000_02A5);
    chk("sw_ld_err", er, 0);
    chk("sw_ld_no_wr", n_wr - wr0, 0);
    do_acc(0, BASE + 32'h00, 32'h0, rd, er);
    chk("hex_ld_data", rd, 32'hDEAD_BEEF);

    // Illegal or unmapped accesses.
    wr0 = n_wr;
    do_acc(1, BASE + 32'h10, 32'hFF, rd, er);
    chk("st_key_err", er, 1);
    do_acc(0, BASE + 32'h20, 32'h0, rd, er);
    chk("ld_20_err", er, 1);
    chk("ld_20_data", rd, 0);
    do_acc(0, BASE + 32'h02, 32'h0, rd, er);
    chk("ld_02_err", er, 1);
    chk("ld_02_data", rd, 0);
    do_acc(0, 32'h0000_0018, 32'h0, rd, er);
    chk("ld_outside_err", er, 1);
    do_acc(1, BASE + 32'h14, 32'h3, rd, er);
    chk("st_sw_err", er, 1);
    chk("illegal_no_wr", n_wr - wr0, 0);

    // Key events: 0 -> 5 sets events 5; read clears; held value sets nothing.
    dev_val[0] = 32'h5;
    repeat (8) @(negedge clk);
    chk("evt_irq_set", bus.key_irq, 1);
    do_acc(0, BASE + 32'h18, 32'h0, rd, er);
    chk("evt_rd_data", rd, 32'h5);
    chk("evt_rd_err", er, 0);
    @(negedge clk);
    chk("evt_irq_clr", bus.key_irq, 0);
    repeat (12) @(negedge clk);
    chk("evt_held_quiet", bus.key_irq, 0);

    // W1C clears only the masked bit.
    dev_val[0] = 32'h0;
    repeat (8) @(negedge clk);
    dev_val[0] = 32'hA;
    repeat (8) @(negedge clk);
    chk("w1c_irq_pre", bus.key_irq, 1);
    do_acc(1, BASE + 32'h18, 32'h2, rd, er);
    chk("w1c_err", er, 0);
    do_acc(0, BASE + 32'h18, 32'h0, rd, er);
    chk("w1c_rd_data", rd, 32'h8);

    // Varying gaps so requests land on pending polls; reference checks every cycle.
    for (int g = 0; g < 8; g++) begin
      case (g)
        0: dev_val[0] = 32'h1;
        1: dev_val[0] = 32'h3;
        2: dev_val[0] = 32'h2;
        3: dev_val[0] = 32'h6;
        4: dev_val[0] = 32'h4;
        5: dev_val[0] = 32'hC;
        6: dev_val[0] = 32'h8;
        default: dev_val[0] = 32'h0;
      endcase
      dev_val[1] = 32'h111 * g;
      repeat (g % 4) @(negedge clk);
      do_acc(0, BASE + 32'h14, 32'h0, rd, er);
      chk("mix_sw_data", rd, 32'h111 * g);
    end
    do_acc(0, BASE + 32'h18, 32'h0, rd, er);

    // Reset during the ACCESS cycle of a LEDR store: no ack, reset state.
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = BASE + 32'h04;
    bus.cpu_wdata = 32'h55;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (bus.ui_wrt_en === 1'b1) seen = 1;
    end
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    chk("rst_mid_reached", seen, 1);
    @(negedge clk);
    chk("rst_mid_ack", bus.cpu_ack, 0);
    chk("rst_mid_wr", bus.ui_wrt_en, 0);
    chk("rst_mid_wdata", bus.ui_wdata, 0);
    @(negedge clk);
    reset = 1'b0;
    do_acc(1, BASE + 32'h04, 32'h77, rd, er);
    chk("post_rst_err", er, 0);
    chk("post_rst_wdata", last_wr_dat, 32'h77);
    chk("post_rst_dev", last_wr_dev, 2);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
